ibex_wb_commit: RTL

// - Single-entry writeback stage directly downstream of the execute block: captures the
//   EX result (ALU/mult-div) or tracks an outstanding LSU access, then commits to the register file.
// - Sits between ID/EX and the register-file write port.
// - Exposes the held destination and data so ID can forward from writeback and detect load hazards.

---
 rtl/ibex_wb_commit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ibex_wb_commit.sv
// rtl/ibex_wb_commit.sv - single-entry writeback stage: holds EX result or tracks LSU access, commits to RF
module ibex_wb_commit #(
  parameter bit ResetAll   = 1'b0,
  parameter bit SuppressX0 = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_wb_i,
  input  logic [1:0]  instr_type_i,
  input  logic        rf_we_id_i,
  input  logic [4:0]  rf_waddr_id_i,
  input  logic [31:0] rf_wdata_ex_i,
  input  logic        lsu_resp_valid_i,
  input  logic        lsu_resp_err_i,
  input  logic [31:0] lsu_rdata_i,
  output logic        ready_wb_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        instr_done_o,
  output logic        lsu_err_o,
  output logic        outstanding_load_o,
  output logic        fwd_valid_o,
  output logic [31:0] fwd_data_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REG      = 2'd1,
    WAIT_LSU = 2'd2
  } state_e;

  state_e      state_q;
  logic        is_load_q;
  logic        we_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;

  logic accept;
  logic new_is_mem;
  logic new_is_load;
  logic lsu_done;
  logic waddr_ok;

  // Reserved type 3 decodes as REG alongside type 0.
  assign new_is_load = (instr_type_i == 2'd1);
  assign new_is_mem  = (instr_type_i == 2'd1) | (instr_type_i == 2'd2);

  assign lsu_done     = (state_q == WAIT_LSU) & lsu_resp_valid_i;
  assign instr_done_o = (state_q == REG) | lsu_done;
  assign ready_wb_o   = (state_q == IDLE) | instr_done_o;
  assign accept       = en_wb_i & ready_wb_o;

  assign waddr_ok = !SuppressX0 || (waddr_q != 5'd0);

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = 5'd0;
    rf_wdata_o = 32'd0;
    lsu_err_o  = 1'b0;
    unique case (state_q)
      REG: begin
        rf_we_o    = we_q & waddr_ok;
        rf_waddr_o = waddr_q;
        rf_wdata_o = wdata_q;
      end
      WAIT_LSU: begin
        rf_waddr_o = waddr_q;
        lsu_err_o  = lsu_done & lsu_resp_err_i;
        if (is_load_q) begin
          rf_wdata_o = lsu_rdata_i;
          rf_we_o    = lsu_done & !lsu_resp_err_i & we_q & waddr_ok;
        end
      end
      default: ;
    endcase
  end

  assign outstanding_load_o = (state_q == WAIT_LSU) & is_load_q;
  assign fwd_valid_o        = (state_q == REG) & we_q;
  assign fwd_data_o         = (state_q == REG) ? wdata_q : 32'd0;

  // A retiring instruction and a newly accepted one share the edge; the new one wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      is_load_q <= 1'b0;
      we_q      <= 1'b0;
    end else if (accept) begin
      state_q   <= new_is_mem ? WAIT_LSU : REG;
      is_load_q <= new_is_load;
      we_q      <= rf_we_id_i;
    end else if (instr_done_o) begin
      state_q   <= IDLE;
    end
  end

  if (ResetAll) begin : g_dp_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        waddr_q <= 5'd0;
        wdata_q <= 32'd0;
      end else if (accept) begin
        waddr_q <= rf_waddr_id_i;
        if (!new_is_mem) wdata_q <= rf_wdata_ex_i;
      end
    end
  end else begin : g_dp_norst
    always_ff @(posedge clk_i) begin
      if (accept) begin
        waddr_q <= rf_waddr_id_i;
        if (!new_is_mem) wdata_q <= rf_wdata_ex_i;
      end
    end
  end

  a_resp_only_when_waiting : assert property (@(posedge clk_i) disable iff (!rst_ni)
    lsu_resp_valid_i |-> (state_q == WAIT_LSU));

  a_no_en_when_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
    en_wb_i |-> ready_wb_o);

endmodule
